// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer and accumulator blocks.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAC_IN_W  = 16;
  localparam int MAC_OUT_W = 32;
  localparam int ACC_W_DEF = 40;
  localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/mac_acc_reg.sv
// Wide accumulator register: clear, load-with-value and add-enable, in that priority.
module mac_acc_reg
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [ACC_W-1:0] load_val,
  input  logic             add_en,
  input  logic [ACC_W-1:0] add_val,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (add_en) begin
      acc <= acc + add_val;
    end
  end

endmodule

// File: rtl/mac_vec_accum.sv
// Dot-product sequencer: streams operand pairs into an external MAC stage,
// injects the bias on the first element only, and accumulates registered results.
module mac_vec_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [MAC_IN_W-1:0]  bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAC_IN_W-1:0]  in_a,
  input  logic [MAC_IN_W-1:0]  in_b,
  output logic [MAC_IN_W-1:0]  mac_a,
  output logic [MAC_IN_W-1:0]  mac_b,
  output logic [MAC_IN_W-1:0]  mac_c,
  input  logic [MAC_OUT_W-1:0] mac_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t               state_reg, state_next;
  logic [LEN_W-1:0]     len_q, issued_reg, retired_reg;
  logic [MAC_IN_W-1:0]  bias_q;
  logic                 pipe_v_reg;
  logic                 acc_clr, acc_load;
  logic                 xfer, last_retire;
  logic [ACC_W-1:0]     acc;

  assign xfer        = in_valid & in_ready;
  // The final retire is the one that brings retired up to the latched length.
  assign last_retire = pipe_v_reg && ((retired_reg + LEN_ONE) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    acc_clr    = 1'b0;
    acc_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            acc_clr    = 1'b1;
            state_next = RUN;
          end else begin
            acc_load   = 1'b1;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        in_ready = (issued_reg < len_q);
        if (last_retire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      bias_q      <= '0;
      issued_reg  <= '0;
      retired_reg <= '0;
      pipe_v_reg  <= 1'b0;
      mac_a       <= '0;
      mac_b       <= '0;
      mac_c       <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        len_q       <= len;
        bias_q      <= bias;
        issued_reg  <= '0;
        retired_reg <= '0;
      end
      // Operand regs hold through bubbles; only pipe_v marks a live element.
      pipe_v_reg <= xfer;
      if (xfer) begin
        mac_a      <= in_a;
        mac_b      <= in_b;
        mac_c      <= (issued_reg == '0) ? bias_q : '0;
        issued_reg <= issued_reg + LEN_ONE;
      end
      if (pipe_v_reg) begin
        retired_reg <= retired_reg + LEN_ONE;
      end
    end
  end

  mac_acc_reg #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .load     (acc_load),
    .load_val ({{(ACC_W-MAC_IN_W){1'b0}}, bias}),
    .add_en   (pipe_v_reg),
    .add_val  ({{(ACC_W-MAC_OUT_W){1'b0}}, mac_r}),
    .acc      (acc)
  );

  assign out_data = acc;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mac_vec_accum.sv
// Self-checking bench for mac_vec_accum with an exact MAC model driving mac_r.
module tb_mac_vec_accum;

  localparam int ACC_W = 40;
  localparam int LEN_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [15:0]       bias;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_a, in_b;
  logic [15:0]       mac_a, mac_b, mac_c;
  logic [31:0]       mac_r;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] op_a [256];
  logic [15:0] op_b [256];

  always #5 clk = ~clk;

  // Exact MAC stage: R = A*B + C
  assign mac_r = ({16'h0, mac_a} * {16'h0, mac_b}) + {16'h0, mac_c};

  mac_vec_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_r(mac_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  typedef struct {
    int                n;
    logic [15:0]       bv;
    int                gap;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [ACC_W-1:0]  exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Dot product from first principles: bias once plus sum of exact products.
  function automatic logic [ACC_W-1:0] model_sum(input int n, input logic [15:0] bv);
    logic [ACC_W-1:0] s;
    s = ACC_W'(bv);
    for (int i = 0; i < n; i++) s = s + ACC_W'(op_a[i]) * ACC_W'(op_b[i]);
    return s;
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, "_in_ready"},  64'(in_ready),  64'd0);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_out_data"},  64'(out_data),  64'd0);
    chk({nm, "_mac_a"},     64'(mac_a),     64'd0);
    chk({nm, "_mac_b"},     64'(mac_b),     64'd0);
    chk({nm, "_mac_c"},     64'(mac_c),     64'd0);
    chk({nm, "_busy"},      64'(busy),      64'd0);
  endtask

  // gap: 0 full rate, 1 every other cycle, 2 random. hold: cycles of out_ready=0 in DONE.
  task automatic run_vector(input int n, input logic [15:0] bv, input int gap, input int hold,
                            input logic [ACC_W-1:0] exp, input string nm);
    logic [15:0] c_before;
    int idx, cyc, xfers, last_cyc, done_cyc, pend_idx;
    bit pend, extra, tmo, stable;
    idx = 0; cyc = 0; xfers = 0; last_cyc = -1; done_cyc = -1; pend_idx = 0;
    pend = 0; extra = 0; tmo = 0; stable = 1;
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    c_before = mac_c;
    start = 1'b1; len = LEN_W'(n); bias = bv;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    forever begin
      if (pend) begin
        chk({nm, "_mac_a"}, 64'(mac_a), 64'(op_a[pend_idx]));
        chk({nm, "_mac_b"}, 64'(mac_b), 64'(op_b[pend_idx]));
        chk({nm, "_mac_c"}, 64'(mac_c), (pend_idx == 0) ? 64'(bv) : 64'd0);
        pend = 0;
      end
      if (out_valid) begin
        done_cyc = cyc;
        break;
      end
      if (cyc > 2000) begin
        tmo = 1;
        break;
      end
      if (in_ready && idx >= n) extra = 1;
      if (idx < n && (gap == 0 || (gap == 1 && cyc % 2 == 1) || (gap == 2 && $urandom_range(1, 0) == 1))) begin
        in_valid = 1'b1; in_a = op_a[idx]; in_b = op_b[idx];
      end else begin
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
      end
      if (in_valid && in_ready) begin
        pend = 1; pend_idx = idx; idx++; xfers++; last_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({nm, "_timeout"}, 64'(tmo), 64'd0);
    chk({nm, "_out_data"}, 64'(out_data), 64'(exp));
    chk({nm, "_xfers"}, 64'(xfers), 64'(n));
    chk({nm, "_extra_ready"}, 64'(extra), 64'd0);
    if (n > 0) chk({nm, "_latency"}, 64'(done_cyc - last_cyc), 64'd2);
    else begin
      chk({nm, "_latency"}, 64'(done_cyc), 64'd1);
      chk({nm, "_mac_c_held"}, 64'(mac_c), 64'(c_before));
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = (h == 2); len = 8'd7; bias = 16'h5555;
      if (!out_valid || out_data !== exp) stable = 0;
      @(negedge clk);
    end
    start = 1'b0;
    if (hold > 0) chk({nm, "_hold_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_data_kept"}, 64'(out_data), 64'(exp));
    $display("vector %s len=%0d bias=%0h result=%0h expected=%0h", nm, n, bv, out_data, exp);
  endtask

  vec_t tbl [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    logic [15:0] bv;
    rst_n = 1'b0; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    tbl[0].n = 3; tbl[0].bv = 16'd5; tbl[0].gap = 0;
    tbl[0].a = {16'd0, 16'd6, 16'd4, 16'd2}; tbl[0].b = {16'd0, 16'd7, 16'd5, 16'd3};
    tbl[0].exp = 40'd73;
    tbl[1].n = 0; tbl[1].bv = 16'h1234; tbl[1].gap = 0;
    tbl[1].a = '0; tbl[1].b = '0; tbl[1].exp = 40'h1234;
    tbl[2].n = 4; tbl[2].bv = 16'hFFFF; tbl[2].gap = 1;
    tbl[2].a = {4{16'hFFFF}}; tbl[2].b = {4{16'hFFFF}};
    tbl[2].exp = 40'h3_FFF9_0003;
    tbl[3].n = 2; tbl[3].bv = 16'd1; tbl[3].gap = 0;
    tbl[3].a = {16'd0, 16'd0, 16'h0100, 16'd1}; tbl[3].b = {16'd0, 16'd0, 16'h0100, 16'hFFFF};
    tbl[3].exp = 40'h2_0000;

    #1;
    check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_reset");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        op_a[i] = tbl[r].a[i];
        op_b[i] = tbl[r].b[i];
      end
      run_vector(tbl[r].n, tbl[r].bv, tbl[r].gap, 0, tbl[r].exp, $sformatf("table%0d", r));
    end

    // DONE held with out_ready low while start is pulsed
    op_a[0] = 16'd300; op_b[0] = 16'd11; op_a[1] = 16'd9; op_b[1] = 16'd1000;
    run_vector(2, 16'd17, 0, 5, model_sum(2, 16'd17), "hold");

    // Asynchronous reset after the 2nd of 4 elements
    for (int i = 0; i < 4; i++) begin op_a[i] = 16'(i + 10); op_b[i] = 16'(i + 20); end
    @(negedge clk);
    start = 1'b1; len = 8'd4; bias = 16'd9;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      in_valid = 1'b1; in_a = op_a[cnt]; in_b = op_b[cnt];
      if (in_ready) cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("abort_fed", 64'(cnt), 64'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    op_a[0] = 16'd3; op_b[0] = 16'd3;
    run_vector(1, 16'd0, 0, 0, 40'd9, "post_reset");

    // Random vectors with random gaps, then a full-length full-rate vector
    for (int v = 0; v < 6; v++) begin
      n = $urandom_range(20, 1);
      bv = 16'($urandom);
      for (int i = 0; i < n; i++) begin op_a[i] = 16'($urandom); op_b[i] = 16'($urandom); end
      run_vector(n, bv, 2, 0, model_sum(n, bv), $sformatf("rand%0d", v));
    end
    bv = 16'($urandom);
    for (int i = 0; i < 255; i++) begin op_a[i] = 16'($urandom); op_b[i] = 16'($urandom); end
    run_vector(255, bv, 0, 0, model_sum(255, bv), "len255");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
